mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares the single memory/peripheral bus (memory_cont plus peripherals) between two masters: m0 is the criscv CPU and m1 is a second master such as a DMA or boot loader.
- Arbitrates round-robin, registers the winning request onto the slave side and routes the response back to the winner.
- Recovers with a timeout when no slave answers.
- Sits between the masters and the existing `read_data` mux / `rec` OR in top.

Parameters:
- TIMEOUT_CYCLES, 255: cycles to wait for s_rec before aborting (range 1..65535).
- ERR_DATA, 32'h0000_0000: read data returned on timeout.

Ports:
- mclk  in  1  clock
- reset  in  1  synchronous active-high reset
- m0_address  in  32  master 0 address
- m0_rw_req  in  1  master 0 request; held high until m0_rec
- m0_rw  in  1  1=write, 0=read
- m0_write_data  in  32  write data
- m0_size  in  2  0=byte, 1=half, 2=word
- m0_read_data  out  32  read data, valid when m0_rec=1
- m0_rec  out  1  one-cycle completion pulse
- m1_address, m1_rw_req, m1_rw, m1_write_data, m1_size, m1_read_data, m1_rec: same as the m0 ports, for master 1
- s_address  out  32  to slaves
- s_rw_req  out  1  to slaves
- s_rw  out  1  to slaves
- s_write_data  out  32  to slaves
- s_size  out  2  to slaves
- s_read_data  in  32  from the top-level read mux
- s_rec  in  1  from the top-level OR of slave valid signals
- grant  out  1  owner of the current or last transaction (0=m0, 1=m1)
- bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (sync): state=IDLE.
  - All s_* outputs are 0.
  - m0_rec, m1_rec and bus_err are 0.
  - m0_read_data and m1_read_data are 0.
  - grant=1, so m0 wins the first tie.
  - Timeout counter is 0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Sample both rw_req.
  - Only one requesting: that master wins.
  - Both requesting: the master != grant wins (round-robin).
  - At the clock edge, latch the winner's address, rw, write_data and size into s_*, set s_rw_req=1, update grant, clear the counter, go to WAIT.
  - Latency: request high in cycle N gives s_rw_req high in cycle N+1.
- WAIT:
  - s_* held stable, s_rw_req=1, counter increments each cycle.
  - s_rec=1: capture s_read_data into the winner's read_data register, drop s_rw_req, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with s_rec=0: load ERR_DATA into the winner's read_data, drop s_rw_req, pulse bus_err during RESP, go to RESP.
  - s_rec and timeout in the same cycle: s_rec wins, no bus_err.
- RESP (exactly 1 cycle):
  - winner's m_rec=1, s_rw_req=0, then go to IDLE.
  - The master must drop rw_req on the edge after it sees rec. The RESP cycle guarantees the old request is never re-sampled in IDLE.
  - Minimum back-to-back spacing is 3 cycles per transaction plus slave latency.
- Read data:
  - Per-master read_data registers update only on completion and hold otherwise.
  - The non-winning master's read_data and rec are untouched.
- Misc:
  - s_rec outside WAIT is ignored.
  - A master dropping rw_req mid-transaction is a protocol violation: the transaction still completes and rec still pulses.
  - Writes return m_rec the same way; read_data is updated with whatever s_read_data carries, which is don't-care for writes.
  - Reset mid-transaction: returns to IDLE next cycle with s_rw_req=0 and no rec pulse.
  - Counter width is clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.

Decomposition:
- Package bus_pkg holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - size codes SZ_BYTE, SZ_HALF, SZ_WORD;
  - RW_READ and RW_WRITE.
- One sub-module, rr_arbiter2: a 2-input round-robin pick with inputs req[1:0] and last, and output winner. It is combinational and reused by the peripherals bus later.
- The FSM, timeout counter and data registers live in mem_bus_arbiter.

Test Plan:
- Single m0 read: m0 read of 0x0000_0100, slave answers s_rec after 2 cycles with 0x1234_5678 -> s_rw_req high from cycle N+1, m0_rec pulses once with m0_read_data=0x1234_5678, m1_rec stays 0, grant=0.
- Simultaneous requests after reset: m0 and m1 request in the same cycle -> m0 served first and m1 served next (grant 0 then 1), with s_address matching each master's address. Repeating the test gives 0,1,0,1 alternation.
- Stable write: m1 word write 0xDEAD_BEEF to 0x8000_0004 -> s_rw=1, s_size=2, s_write_data=0xDEAD_BEEF, all held unchanged for every WAIT cycle until s_rec, then m1_rec pulses.
- Timeout: TIMEOUT_CYCLES=8, m0 read with no s_rec -> s_rw_req drops after 8 cycles in WAIT, bus_err and m0_rec pulse together, m0_read_data=ERR_DATA.
- Reset mid-WAIT: reset asserted in the 3rd WAIT cycle -> next cycle s_rw_req=0, no rec pulse, grant=1, and a new m1 request is granted normally.
- Late s_rec and collisions: s_rec pulse while in IDLE -> no m_rec and no state change. s_rec together with timeout expiry -> normal completion, bus_err=0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the memory/peripheral bus: FSM encoding, access
// size codes, read/write codes and the request bundle a master presents.
package bus_pkg;

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Access size codes carried on *_size
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Direction codes carried on *_rw
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Everything a master drives toward the slaves for one transfer
    typedef struct packed {
        logic [31:0] address;
        logic        rw;
        logic [31:0] write_data;
        logic [1:0]  size;
    } bus_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick. A lone requester always wins; on a tie the
// requester that did not win last time gets the bus. Purely combinational
// so the caller decides when the choice is committed.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    // Pick the winner from the request pair and the previous owner
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        winner = last;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = last;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory/peripheral bus between the CPU (m0) and a second
// master (m1). The winning request is registered onto the slave side, held
// until a slave answers or the timeout expires, and the response is returned
// to the winner as a one-cycle rec pulse.
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
    input  logic        mclk,
    input  logic        reset,

    input  logic [31:0] m0_address,
    input  logic        m0_rw_req,
    input  logic        m0_rw,
    input  logic [31:0] m0_write_data,
    input  logic [1:0]  m0_size,
    output logic [31:0] m0_read_data,
    output logic        m0_rec,

    input  logic [31:0] m1_address,
    input  logic        m1_rw_req,
    input  logic        m1_rw,
    input  logic [31:0] m1_write_data,
    input  logic [1:0]  m1_size,
    output logic [31:0] m1_read_data,
    output logic        m1_rec,

    output logic [31:0] s_address,
    output logic        s_rw_req,
    output logic        s_rw,
    output logic [31:0] s_write_data,
    output logic [1:0]  s_size,
    input  logic [31:0] s_read_data,
    input  logic        s_rec,

    output logic        grant,
    output logic        bus_err
);

    // Counter wide enough to hold TIMEOUT_CYCLES itself, where it parks
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);

    logic [1:0]       r_state;
    bus_req_t         r_req;
    logic             r_s_rw_req;
    logic             r_grant;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_m0_rdata;
    logic [31:0]      r_m1_rdata;
    logic             r_m0_rec;
    logic             r_m1_rec;
    logic             r_bus_err;

    logic             w_winner;
    logic             w_any_req;
    bus_req_t         w_win_req;
    logic             w_in_wait;
    logic             w_timeout;
    logic             w_done;
    logic             w_err;
    logic [31:0]      w_rdata;

    rr_arbiter2 u_rr (
        .req    ({m1_rw_req, m0_rw_req}),
        .last   (r_grant),
        .winner (w_winner)
    );

    assign w_any_req = m0_rw_req | m1_rw_req;
    assign w_win_req = w_winner
                     ? '{address: m1_address, rw: m1_rw, write_data: m1_write_data, size: m1_size}
                     : '{address: m0_address, rw: m0_rw, write_data: m0_write_data, size: m0_size};

    // s_rec only counts while waiting; a slave answer wins over a timeout in the same cycle
    assign w_in_wait = (r_state == ST_WAIT);
    assign w_timeout = (r_cnt == CNT_LAST);
    assign w_done    = w_in_wait & (s_rec | w_timeout);
    assign w_err     = w_in_wait & ~s_rec & w_timeout;
    assign w_rdata   = s_rec ? s_read_data : ERR_DATA;

    // FSM: grant in IDLE, hold the slave request in WAIT, one RESP cycle before re-arbitrating
    always_ff @(posedge mclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            r_state    <= ST_IDLE;
            r_req      <= '0;
            r_s_rw_req <= 1'b0;
            r_grant    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_req      <= w_win_req;
                        r_s_rw_req <= 1'b1;
                        r_grant    <= w_winner;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_done) begin
                        r_s_rw_req <= 1'b0;
                        r_state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_s_rw_req <= 1'b0;
                end
            endcase
        end
    end

    // Timeout counter: cleared on grant, counts WAIT cycles, parks at its ceiling
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_cnt <= '0;
        end else if (w_in_wait && r_cnt != CNT_SAT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Response path: capture data for the owner only, pulse rec/bus_err for the RESP cycle
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
            r_m0_rec   <= 1'b0;
            r_m1_rec   <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_m0_rec  <= 1'b0;
            r_m1_rec  <= 1'b0;
            r_bus_err <= w_err;
            if (w_done) begin
                if (r_grant) begin
                    r_m1_rdata <= w_rdata;
                    r_m1_rec   <= 1'b1;
                end else begin
                    r_m0_rdata <= w_rdata;
                    r_m0_rec   <= 1'b1;
                end
            end
        end
    end

    assign s_address    = r_req.address;
    assign s_rw         = r_req.rw;
    assign s_write_data = r_req.write_data;
    assign s_size       = r_req.size;
    assign s_rw_req     = r_s_rw_req;
    assign grant        = r_grant;
    assign bus_err      = r_bus_err;
    assign m0_read_data = r_m0_rdata;
    assign m1_read_data = r_m1_rdata;
    assign m0_rec       = r_m0_rec;
    assign m1_rec       = r_m1_rec;

endmodule
